// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches halfwords, issues them to the control unit, and supports branches, single injected instructions and halt.
// Optional macro IFU_INSTR_COUNT_EN adds issue_count_o, a count of issued instructions.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic [15:0] instr_o,
  output logic        instr_valid_o,
  input  logic [15:0] self_instruct_i,
  input  logic        self_instruct_en_i,
  input  logic        branch_i,
  input  logic [15:0] branch_target_i,
  input  logic        end_program_i,
  output logic [15:0] pc_o,
  output logic        halted_o
`ifdef IFU_INSTR_COUNT_EN
  ,
  output logic [15:0] issue_count_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_INJECT,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] word_q, word_d;
  logic [15:0] inj_q, inj_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      word_q  <= '0;
      inj_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      inj_q   <= inj_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    word_d        = word_q;
    inj_d         = inj_q;
    imem_req_o    = 1'b0;
    imem_addr_o   = '0;
    instr_o       = '0;
    instr_valid_o = 1'b0;
    halted_o      = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        halted_o = (state_q == S_HALT);
        if (start_i) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
        if (imem_valid_i) begin
          word_d  = imem_rdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid_o = 1'b1;
        instr_o       = word_q;
        if (end_program_i) begin
          state_d = S_HALT;
        end else if (branch_i) begin
          // Targets are halfword aligned; a stray low bit is dropped.
          pc_d    = {branch_target_i[15:1], 1'b0};
          state_d = S_FETCH;
        end else if (self_instruct_en_i) begin
          inj_d   = self_instruct_i;
          pc_d    = pc_q + 16'd2;
          state_d = S_INJECT;
        end else begin
          pc_d    = pc_q + 16'd2;
          state_d = S_FETCH;
        end
      end
      S_INJECT: begin
        // Control inputs are deliberately ignored here so injections cannot chain.
        instr_valid_o = 1'b1;
        instr_o       = inj_q;
        state_d       = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc_o = pc_q;

`ifdef IFU_INSTR_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (start_i && (state_q == S_IDLE || state_q == S_HALT)) begin
      count_q <= '0;
    end else if (instr_valid_o) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign issue_count_o = count_q;
`endif

endmodule
